fetch_queue: RTL and testbench

Parametrised prefetching instruction fetch unit for the core front end. It streams sequential requests into a fixed-latency instruction ROM, one per cycle. Returned words are buffered with their PCs in a small queue, and decode pulls them through a valid/ready handshake. A redirect (branch, jump or trap) flushes all buffered and in-flight fetches and restarts fetching at a new PC.

---
 rtl/fetch_queue.sv | 104 ++++++++++
 tb/tb_fetch_queue.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Prefetching instruction fetch unit: streams sequential requests into a
// fixed-latency ROM and buffers returned words with their PCs for decode.
module fetch_queue #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       DEPTH       = 4,
  parameter int unsigned       ROM_LATENCY = 2,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       rom_en,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [DATA_W-1:0]          rom_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [DATA_W-1:0]          out_instr,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = $clog2(DEPTH + ROM_LATENCY + 1);

  logic [ADDR_W-1:0]      pc;
  logic [ROM_LATENCY-1:0] fl_valid;
  logic [ADDR_W-1:0]      fl_pc [ROM_LATENCY];
  logic [ADDR_W-1:0]      q_pc [DEPTH];
  logic [DATA_W-1:0]      q_instr [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [SUM_W-1:0]       inflight_count;
  logic                   enq;
  logic                   deq;

  always_comb begin
    inflight_count = '0;
    for (int i = 0; i < ROM_LATENCY; i++)
      inflight_count = inflight_count + SUM_W'(fl_valid[i]);
  end

  // Credit: every issued request must have a guaranteed queue slot on return.
  assign rom_en    = !rst && !redirect_valid &&
                     ((SUM_W'(occupancy) + inflight_count) < SUM_W'(DEPTH));
  assign rom_addr  = pc;
  assign enq       = fl_valid[ROM_LATENCY-1] && !redirect_valid;
  assign out_valid = (occupancy != '0);
  assign deq       = out_valid && out_ready;
  assign out_pc    = q_pc[rd_ptr];
  assign out_instr = q_instr[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc <= RESET_PC;
    else if (redirect_valid)
      pc <= redirect_pc & ~ADDR_W'(3);
    else if (rom_en)
      pc <= pc + ADDR_W'(4);
  end

  // In-flight tags; a redirect kills every outstanding return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fl_valid <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) fl_pc[i] <= '0;
    end else begin
      for (int i = ROM_LATENCY - 1; i > 0; i--) begin
        fl_valid[i] <= fl_valid[i-1] && !redirect_valid;
        fl_pc[i]    <= fl_pc[i-1];
      end
      fl_valid[0] <= rom_en;
      fl_pc[0]    <= pc;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_pc[wr_ptr]    <= fl_pc[ROM_LATENCY-1];
      q_instr[wr_ptr] <= rom_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (redirect_valid) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue over three latency/depth configurations.
module tb_fetch_queue;
  localparam logic [31:0] XM = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int unsigned L    = (g == 0) ? 2 : (g == 1) ? 1 : 3;
    localparam int unsigned D    = (g == 0) ? 4 : (g == 1) ? 2 : 8;
    localparam int unsigned OW   = $clog2(D + 1);
    localparam int          TPUT = (D >= L + 2) ? 12 : 8;

    logic          rst = 1'b0;
    logic          redirect_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [31:0]   redirect_pc = '0;
    logic          rom_en;
    logic          out_valid;
    logic [31:0]   rom_addr;
    logic [31:0]   rom_data;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic [OW-1:0] occupancy;
    logic [31:0]   rom_pipe [L];
    logic [L-1:0]  live;
    logic [31:0]   exp_q [$];
    logic [31:0]   next_pc = '0;
    logic [31:0]   mon_e;
    int unsigned   delivered = 0;
    bit            done = 1'b0;

    fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(D), .ROM_LATENCY(L), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_instr(out_instr), .occupancy(occupancy)
    );

    // ROM returns a scrambled copy of the address L cycles later
    always @(posedge clk) begin
      rom_pipe[0] <= rom_addr;
      for (int i = 1; i < L; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[L-1] ^ XM;

    always @(posedge clk or posedge rst) begin
      if (rst || redirect_valid) live <= '0;
      else begin
        live[0] <= rom_en;
        for (int i = 1; i < L; i++) live[i] <= live[i-1];
      end
    end

    always @(posedge rst) begin
      exp_q.delete();
      next_pc = 32'h0;
    end

    // Issue model: predicts every request address and queues its expected delivery
    always @(negedge clk) begin
      if (!rst) begin
        if (redirect_valid) begin
          chk(rom_en === 1'b0, "no_issue_on_redirect", 32'(rom_en), 32'h0);
          next_pc = {redirect_pc[31:2], 2'b00};
        end else if (rom_en) begin
          chk(rom_addr === next_pc, "issue_addr", rom_addr, next_pc);
          exp_q.push_back(next_pc);
          next_pc = next_pc + 32'd4;
        end
      end
    end

    // Monitor: pops on each handshake; a redirect flushes after the accepted one
    always @(negedge clk) begin
      if (!rst) begin
        if (live[L-1] && !redirect_valid)
          chk(occupancy != OW'(D), "no_overflow", 32'(occupancy), 32'(D - 1));
        if (out_valid && out_ready) begin
          chk(exp_q.size() != 0, "out_unexpected", out_pc, 32'h0);
          if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk(out_pc === mon_e, "out_pc", out_pc, mon_e);
            chk(out_instr === (mon_e ^ XM), "out_instr", out_instr, mon_e ^ XM);
            delivered++;
          end
        end
        if (redirect_valid) exp_q.delete();
      end
    end

    task automatic adv();
      @(posedge clk);
      #1;
    endtask

    task automatic smp();
      @(negedge clk);
    endtask

    // Leaves the caller in the first cycle after reset release
    task automatic sync_reset(input logic rdy);
      adv();
      rst = 1'b1;
      redirect_valid = 1'b0;
      out_ready = rdy;
      adv();
      rst = 1'b0;
    endtask

    initial begin
      int n;
      logic [31:0] got [4];
      #1 rst = 1'b1;
      #1;
      chk(rom_en === 1'b0, "rst_rom_en", 32'(rom_en), 32'h0);
      chk(out_valid === 1'b0, "rst_out_valid", 32'(out_valid), 32'h0);
      chk(occupancy === '0, "rst_occupancy", 32'(occupancy), 32'h0);
      chk(rom_addr === 32'h0, "rst_rom_addr", rom_addr, 32'h0);

      // first requests, latency and sustained rate
      sync_reset(1'b1);
      for (int c = 1; c <= L + 1; c++) begin
        smp();
        chk(rom_en === 1'b1 && rom_addr === 32'(4 * (c - 1)), "issue_seq", rom_addr, 32'(4 * (c - 1)));
        chk(out_valid === 1'b0, "latency_idle", 32'(out_valid), 32'h0);
        adv();
      end
      smp();
      chk(out_valid === 1'b1 && out_pc === 32'h0, "first_out", out_pc, 32'h0);
      adv();
      n = 0;
      for (int c = 0; c < 12; c++) begin
        smp();
        if (out_valid) n++;
        adv();
      end
      chk(n == TPUT, "throughput", 32'(n), 32'(TPUT));

      // asynchronous reset between edges
      #1 rst = 1'b1;
      #1;
      chk(rom_en === 1'b0 && out_valid === 1'b0, "async_rst_out", {30'b0, rom_en, out_valid}, 32'h0);
      chk(occupancy === '0, "async_rst_occ", 32'(occupancy), 32'h0);
      rst = 1'b0;
      smp();
      chk(rom_en === 1'b1 && rom_addr === 32'h0, "restart_pc", rom_addr, 32'h0);
      adv();

      // backpressure: credit stops issue after DEPTH requests
      sync_reset(1'b0);
      n = 0;
      for (int c = 0; c < 20; c++) begin
        smp();
        if (rom_en) n++;
        adv();
      end
      chk(n == D, "bp_requests", 32'(n), 32'(D));
      chk(occupancy == OW'(D), "bp_occupancy", 32'(occupancy), 32'(D));
      out_ready = 1'b1;
      for (int i = 0; i < D; i++) begin
        smp();
        chk(out_valid === 1'b1 && out_pc === 32'(4 * i), "bp_drain", out_pc, 32'(4 * i));
        if (i == 0) chk(rom_en === 1'b0, "bp_no_credit", 32'(rom_en), 32'h0);
        if (i == 1) chk(rom_en === 1'b1 && rom_addr === 32'(4 * D), "bp_resume", rom_addr, 32'(4 * D));
        adv();
      end

      // redirect with returns in flight and a concurrent handshake
      sync_reset(1'b0);
      for (int c = 0; c < L + 2; c++) adv();
      out_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_1002;
      smp();
      chk(out_valid === 1'b1 && occupancy == OW'(2), "redir_state", 32'(occupancy), 32'h2);
      chk(out_pc === 32'h0, "redir_handshake_pc", out_pc, 32'h0);
      adv();
      redirect_valid = 1'b0;
      for (int c = 0; c <= L; c++) begin
        smp();
        chk(out_valid === 1'b0, "redir_bubble", 32'(out_valid), 32'h0);
        if (c == 0) chk(rom_en === 1'b1 && rom_addr === 32'h1000, "redir_first_req", rom_addr, 32'h1000);
        adv();
      end
      smp();
      chk(out_valid === 1'b1 && out_pc === 32'h1000, "redir_first_out", out_pc, 32'h1000);
      adv();

      // back-to-back redirects: the last one wins
      redirect_valid = 1'b1;
      redirect_pc = 32'h100;
      smp();
      chk(rom_en === 1'b0, "b2b_hold0", 32'(rom_en), 32'h0);
      adv();
      redirect_pc = 32'h200;
      smp();
      chk(rom_en === 1'b0, "b2b_hold1", 32'(rom_en), 32'h0);
      adv();
      redirect_valid = 1'b0;
      for (int c = 0; c <= L; c++) begin
        smp();
        if (c == 0) chk(rom_en === 1'b1 && rom_addr === 32'h200, "b2b_first_req", rom_addr, 32'h200);
        chk(out_valid === 1'b0, "b2b_bubble", 32'(out_valid), 32'h0);
        adv();
      end
      smp();
      chk(out_valid === 1'b1 && out_pc === 32'h200, "b2b_first_out", out_pc, 32'h200);
      adv();

      // address wrap
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      adv();
      redirect_valid = 1'b0;
      n = 0;
      for (int c = 0; c < 40 && n < 4; c++) begin
        smp();
        if (out_valid && out_ready) begin
          got[n] = out_pc;
          n++;
        end
        adv();
      end
      chk(n == 4, "wrap_count", 32'(n), 32'h4);
      for (int i = 0; i < 4; i++)
        if (i < n) chk(got[i] === 32'hFFFF_FFF8 + 32'(4 * i), "wrap_pc", got[i], 32'hFFFF_FFF8 + 32'(4 * i));

      // random consumer, sporadic redirects and reset pulses
      for (int c = 0; c < 400; c++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        redirect_valid = ($urandom_range(0, 15) == 0);
        redirect_pc = $urandom();
        if ($urandom_range(0, 127) == 0) begin
          #1 rst = 1'b1;
          #1 rst = 1'b0;
        end
        adv();
      end
      redirect_valid = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) adv();
      chk(delivered >= 80, "liveness", 32'(delivered), 32'd80);
      done = 1'b1;
    end
  end

  initial begin
    int waited;
    waited = 0;
    while (!(cfg[0].done && cfg[1].done && cfg[2].done) && waited < 20000) begin
      @(posedge clk);
      waited++;
    end
    chk(waited < 20000, "timeout", 32'(waited), 32'd20000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
